// File: rtl/window_scan_scheduler.sv
// window_scan_scheduler: walks classifier windows row-major over one integral-image frame
module window_scan_scheduler #(
  parameter int IMG_W   = 160,
  parameter int IMG_H   = 120,
  parameter int WIN     = 24,
  parameter int STEP    = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_start,
  input  logic        scan_abort,
  input  logic        detect_done,
  input  logic        detected_flag,
  output logic        detect_en,
  output logic [14:0] win_base_addr,
  output logic [7:0]  win_x,
  output logic [7:0]  win_y,
  output logic        busy,
  output logic        scan_done,
  output logic [9:0]  hit_count,
  output logic        first_hit_valid,
  output logic [7:0]  first_hit_x,
  output logic [7:0]  first_hit_y,
  output logic        timeout_flag
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [8:0] xs, ys;
  logic [7:0] nx, ny;
  logic [14:0] addr_n;
  logic x_ok, y_ok, last, timed_out, start;
  // next window origin, its base address and end-of-frame detection
  always_comb begin
    xs = {1'b0, win_x} + 9'(STEP);
    ys = {1'b0, win_y} + 9'(STEP);
    x_ok = xs <= 9'(IMG_W - WIN);
    y_ok = ys <= 9'(IMG_H - WIN);
    last = !x_ok && !y_ok;
    nx = x_ok ? xs[7:0] : 8'd0;
    ny = x_ok ? win_y : ys[7:0];
    addr_n = {7'd0, ny} * 15'(IMG_W) + {7'd0, nx};
    timed_out = cnt == CW'(TIMEOUT - 1);
    start = state == IDLE && scan_start && !scan_abort;
  end
  // next-state logic; abort overrides every state
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = scan_start ? ISSUE : IDLE;
      ISSUE:   state_n = WAIT;
      WAIT:    state_n = (detect_done || timed_out) ? NEXT : WAIT;
      NEXT:    state_n = last ? DONE : ISSUE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (scan_abort) state_n = IDLE;
  end
  // state, registered strobes, window walk and result tally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      detect_en <= 1'b0;
      busy <= 1'b0;
      scan_done <= 1'b0;
      cnt <= '0;
      win_x <= '0;
      win_y <= '0;
      win_base_addr <= '0;
      hit_count <= '0;
      first_hit_valid <= 1'b0;
      first_hit_x <= '0;
      first_hit_y <= '0;
      timeout_flag <= 1'b0;
    end else begin
      state <= state_n;
      detect_en <= state_n == ISSUE;
      busy <= state_n inside {ISSUE, WAIT, NEXT};
      scan_done <= state_n == DONE;
      if (start) begin
        cnt <= '0;
        win_x <= '0;
        win_y <= '0;
        win_base_addr <= '0;
        hit_count <= '0;
        first_hit_valid <= 1'b0;
        first_hit_x <= '0;
        first_hit_y <= '0;
        timeout_flag <= 1'b0;
      end else if (!scan_abort && state == WAIT) begin
        cnt <= cnt + 1'b1;
        if (detect_done && detected_flag) begin
          hit_count <= hit_count + {9'd0, ~&hit_count};
          if (!first_hit_valid) begin
            first_hit_valid <= 1'b1;
            first_hit_x <= win_x;
            first_hit_y <= win_y;
          end
        end else if (!detect_done && timed_out) timeout_flag <= 1'b1;
      end else if (!scan_abort && state == NEXT) begin
        cnt <= '0;
        if (!last) begin
          win_x <= nx;
          win_y <= ny;
          win_base_addr <= addr_n;
        end
      end
    end
  end
endmodule

// File: doc/window_scan_scheduler.md
Name: window_scan_scheduler

Overview:
- Sequences the classifier over every sliding-window position of one captured integral-image frame.
- Sits between detection_sm and the classifier, on the ov7670_pclk domain.
- On a scan request it walks window origins in row-major order. For each window it issues one detect_en pulse with the window base address, waits for detect_done, and tallies detections.
- Reports scan completion, hit count, first-hit coordinates and a classifier-timeout flag.

Parameters:
- IMG_W, 160, integral image width in pixels.
- IMG_H, 120, integral image height in pixels.
- WIN, 24, square window side in pixels.
- STEP, 4, window stride in x and y.
- TIMEOUT, 4096, max cycles to wait for detect_done per window.

Ports:
- clk  in  1  pixel clock (ov7670_pclk domain).
- rst  in  1  reset.
- scan_start  in  1  single-cycle request to scan the current frame.
- scan_abort  in  1  single-cycle abort; returns to IDLE.
- detect_done  in  1  classifier finished current window (pulse).
- detected_flag  in  1  classifier result; valid when detect_done=1.
- detect_en  out  1  single-cycle start pulse to classifier.
- win_base_addr  out  15  y*IMG_W+x of current window origin; held while busy.
- win_x  out  8  current window origin x.
- win_y  out  8  current window origin y.
- busy  out  1  scan in progress.
- scan_done  out  1  single-cycle pulse at scan completion.
- hit_count  out  10  detections this scan, saturating at 1023.
- first_hit_valid  out  1  at least one detection this scan.
- first_hit_x  out  8  x of first detecting window.
- first_hit_y  out  8  y of first detecting window.
- timeout_flag  out  1  sticky: some window timed out this scan.

Behaviour:
- Clocking/reset: single clock clk, rising edge. rst is asynchronous, active-high.
- On rst, all outputs are 0 and state is IDLE.
- Registers: all outputs registered; no combinational path from inputs to outputs.
- States: IDLE, ISSUE, WAIT, NEXT, DONE.
- IDLE:
  - busy=0.
  - scan_start=1 → clear hit_count, first_hit_*, timeout_flag, win_x, win_y, win_base_addr and the timeout counter; go to ISSUE.
- ISSUE:
  - busy=1, detect_en=1 for exactly this cycle.
  - win_* and win_base_addr are stable from this cycle until NEXT.
  - Go to WAIT.
- WAIT:
  - Timeout counter increments every cycle.
  - detect_done=1: if detected_flag=1, increment hit_count (saturate at 1023). If first_hit_valid=0, latch first_hit_x/y from win_x/y and set first_hit_valid. Go to NEXT.
  - Counter reaches TIMEOUT-1 with no detect_done: set timeout_flag, count no hit, go to NEXT.
- NEXT:
  - Clear the timeout counter.
  - If win_x+STEP <= IMG_W-WIN: win_x += STEP.
  - Else, if win_y+STEP <= IMG_H-WIN: win_x=0, win_y += STEP.
  - Else go to DONE with no coordinate update.
  - Otherwise go to ISSUE, with win_base_addr = new win_y*IMG_W + new win_x, registered in the same cycle.
- DONE:
  - scan_done=1 for one cycle, busy=0 in the same cycle; go to IDLE.
  - hit_count, first_hit_* and timeout_flag hold until the next accepted scan_start.
- Window counts (defaults): x origins 0..136 (35), y origins 0..96 (25), 875 windows.
- Throughput: per window, 1 ISSUE + N WAIT + 1 NEXT cycles, where N = cycles until detect_done is sampled (N>=1).
- Boundary conditions:
  - scan_start while busy → ignored.
  - detect_done outside WAIT → ignored; not counted.
  - detect_done in the same cycle the timeout fires → detect_done wins; timeout_flag not set.
  - scan_abort in any state → IDLE next cycle. detect_en, busy and scan_done go to 0; no scan_done pulse. Result registers hold their partial values.
  - scan_abort and scan_start in the same cycle → abort wins; start dropped.
  - scan_start in the DONE cycle → ignored; accepted only from IDLE.
  - rst mid-scan → immediate return to reset values.
- Width rules:
  - win_base_addr is computed in 15 bits (max 96*160+136=15496).
  - win_x and win_y are zero-extended to the multiply width.
  - Parameters must satisfy WIN <= IMG_W, WIN <= IMG_H and IMG_W*IMG_H <= 32768.

Test Plan:
- Reset, then scan_start; classifier model returns detect_done 3 cycles after detect_en with detected_flag=0 → exactly 875 detect_en pulses. Last pulse has win_x=136, win_y=96, win_base_addr=15496. One scan_done; hit_count=0, first_hit_valid=0.
- Model asserts detected_flag only for windows (40,20) and (100,60) → hit_count=2, first_hit_x=40, first_hit_y=20. win_base_addr at (40,20) = 3240.
- Model never answers the 5th window → that window lasts exactly 1+TIMEOUT+1 cycles, timeout_flag=1, scan still completes with 875 pulses.
- Pulse scan_abort during WAIT of window 10 → busy=0 next cycle, no scan_done. A new scan_start restarts at (0,0) with hit_count=0.
- scan_start asserted while busy, plus a stray detect_done in IDLE → no restart and no count change.
- Assert rst asynchronously mid-WAIT → all outputs 0 within the same cycle, state IDLE.
